// File: rtl/ssd_scan_ctrl.sv
// Scan controller for a multiplexed 8-digit seven-segment display.
// Double-buffered hex value, per-slot blanking gap, leading-zero suppression and DP mask.
module ssd_scan_ctrl #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SCAN_DIV  = 18,
  parameter int unsigned BLANK_CYC = 1024
) (
  input  logic        ClkPort,
  input  logic        Reset_n,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [7:0]  dp_mask,
  input  logic        zero_blank,
  output logic        ld_ready,
  output logic        frame_done,
  output logic [2:0]  digit_idx,
  output logic [7:0]  An,
  output logic [7:0]  Cath
);

  localparam logic [SCAN_DIV-1:0] TickMax   = '1;
  localparam logic [SCAN_DIV-1:0] BlankCyc  = SCAN_DIV'(BLANK_CYC);
  localparam logic [2:0]          LastDigit = 3'(DIGITS - 1);

  typedef enum logic [0:0] {StBlank, StDrive} state_e;

  state_e              state_q, state_d;
  logic [SCAN_DIV-1:0] tick_q, tick_d;
  logic [2:0]          digit_q, digit_d;
  logic [31:0]         active_q, active_d;
  logic [31:0]         shadow_q, shadow_d;
  logic                pending_q, pending_d;
  logic                ready_q, ready_d;
  logic [7:0]          an_q, an_d;
  logic [7:0]          cath_q, cath_d;

  logic       slot_end;
  logic       frame_end;
  logic [3:0] nib;
  logic       nonzero_high;
  logic       suppress;
  logic [6:0] seg;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign slot_end  = (tick_q == TickMax);
  assign frame_end = slot_end && (digit_q == LastDigit);

  // Slot timing and digit sequencing
  always_comb begin
    tick_d  = tick_q + SCAN_DIV'(1);
    state_d = state_q;
    digit_d = digit_q;
    unique case (state_q)
      StBlank: if (tick_d >= BlankCyc) state_d = StDrive;
      StDrive: if (slot_end && (BlankCyc != '0)) state_d = StBlank;
      default: state_d = StBlank;
    endcase
    if (slot_end) begin
      digit_d = (digit_q == LastDigit) ? 3'd0 : digit_q + 3'd1;
    end
  end

  // Load handshake; ld_ready is only high while nothing is pending, so the two never collide
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    ready_d   = ready_q;
    if (frame_end && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
      ready_d   = 1'b1;
    end
    if (load && ready_q) begin
      shadow_d  = load_data;
      pending_d = 1'b1;
      ready_d   = 1'b0;
    end
  end

  // Outputs are computed from next-state values so they change on the same edge as the FSM
  always_comb begin
    nib          = active_d[{digit_d, 2'b00} +: 4];
    nonzero_high = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if ((k < int'(DIGITS)) && (k >= int'(digit_d)) && (active_d[4*k +: 4] != 4'h0)) begin
        nonzero_high = 1'b1;
      end
    end
    suppress = zero_blank && (digit_d != 3'd0) && !nonzero_high;
    seg      = suppress ? 7'h7F : seg_decode(nib);
    an_d     = 8'hFF;
    cath_d   = 8'hFF;
    if (state_d == StDrive) begin
      an_d   = ~(8'd1 << digit_d);
      cath_d = {seg, ~dp_mask[digit_d]};
    end
  end

  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= StBlank;
      tick_q    <= '0;
      digit_q   <= 3'd0;
      active_q  <= 32'd0;
      shadow_q  <= 32'd0;
      pending_q <= 1'b0;
      ready_q   <= 1'b1;
      an_q      <= 8'hFF;
      cath_q    <= 8'hFF;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      digit_q   <= digit_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      an_q      <= an_d;
      cath_q    <= cath_d;
    end
  end

  assign ld_ready   = ready_q;
  assign frame_done = frame_end;
  assign digit_idx  = digit_q;
  assign An         = an_q;
  assign Cath       = cath_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl with 4 digits, 16-clock slots and a 2-clock blanking gap.
module tb_ssd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [31:0] load_data = 32'd0;
  logic [7:0]  dp_mask = 8'd0;
  logic        zero_blank = 1'b0;
  logic        ld_ready, frame_done;
  logic [2:0]  digit_idx;
  logic [7:0]  An, Cath;

  ssd_scan_ctrl #(
    .DIGITS   (4),
    .SCAN_DIV (4),
    .BLANK_CYC(2)
  ) dut (
    .ClkPort   (clk),
    .Reset_n   (rst_n),
    .load      (load),
    .load_data (load_data),
    .dp_mask   (dp_mask),
    .zero_blank(zero_blank),
    .ld_ready  (ld_ready),
    .frame_done(frame_done),
    .digit_idx (digit_idx),
    .An        (An),
    .Cath      (Cath)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     data;
    logic [7:0]      dp;
    logic            zb;
    logic            extra;     // follow with an ignored load of all-ones
    logic            at_fd;     // load on the frame_done clock
    logic [3:0][7:0] exp_cath;  // [k] = Cath while digit k is driven
  } vec_t;

  vec_t            vecs[8];
  logic [7:0]      exp_q[$];
  logic [3:0][7:0] prev_exp;
  int              n_tests = 0;
  int              n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Checks one full frame; Cath of each driven slot is popped from the scoreboard
  task automatic check_frame(input bit first_now);
    logic [7:0] cur;
    logic [7:0] e_an;
    int slot, pos;
    cur = 8'hFF;
    for (int c = 0; c < 64; c++) begin
      if (c == 0 && first_now) #1;
      else @(negedge clk);
      slot = c / 16;
      pos  = c % 16;
      e_an = (pos < 2) ? 8'hFF : ~(8'd1 << slot);
      if (c == 0) chk("ld_ready_frame_start", {31'd0, ld_ready}, 32'd1);
      chk("an", {24'd0, An}, {24'd0, e_an});
      chk("digit_idx", {29'd0, digit_idx}, slot);
      chk("frame_done", {31'd0, frame_done}, (c == 63) ? 32'd1 : 32'd0);
      if (pos < 2) begin
        chk("cath_blank", {24'd0, Cath}, 32'hFF);
      end else begin
        if (pos == 2) begin
          if (exp_q.size() == 0) fail_now("scoreboard_underflow");
          else cur = exp_q.pop_front();
        end
        chk("cath", {24'd0, Cath}, {24'd0, cur});
      end
    end
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  // Until frame_done, the previously committed value must still be on display
  task automatic wait_fd_hold();
    bit seen;
    logic [7:0] e;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
      end else if (An != 8'hFF) begin
        e = prev_exp[digit_idx[1:0]];
        chk("hold_old_value", {24'd0, Cath}, {24'd0, e});
      end
    end
    if (!seen) fail_now("timeout_frame_done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h00001234, 8'h00, 1'b0, 1'b1, 1'b0, {8'h9F, 8'h25, 8'h0D, 8'h99}};
    vecs[1] = '{32'h00000005, 8'h00, 1'b1, 1'b0, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'h49}};
    vecs[2] = '{32'h00000500, 8'h00, 1'b1, 1'b0, 1'b0, {8'hFF, 8'h49, 8'h03, 8'h03}};
    vecs[3] = '{32'h0000ABCD, 8'h01, 1'b0, 1'b0, 1'b1, {8'h11, 8'hC1, 8'h63, 8'h84}};
    vecs[4] = '{32'h00000000, 8'h0A, 1'b1, 1'b0, 1'b0, {8'hFE, 8'hFF, 8'hFE, 8'h03}};
    vecs[5] = '{32'h0000EF00, 8'h00, 1'b1, 1'b0, 1'b0, {8'h61, 8'h71, 8'h03, 8'h03}};
    vecs[6] = '{32'h12340000, 8'h00, 1'b1, 1'b0, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'h03}};
    vecs[7] = '{32'h00006789, 8'h00, 1'b0, 1'b1, 1'b0, {8'h41, 8'h1F, 8'h01, 8'h09}};

    #12;
    chk("rst_an", {24'd0, An}, 32'hFF);
    chk("rst_cath", {24'd0, Cath}, 32'hFF);
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_digit_idx", {29'd0, digit_idx}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) exp_q.push_back(8'h03);
    prev_exp = {4{8'h03}};
    check_frame(1'b1);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].at_fd) chk("fd_before_load", {31'd0, frame_done}, 32'd1);
      else repeat ($urandom_range(3, 30)) @(negedge clk);
      load      = 1'b1;
      load_data = vecs[v].data;
      @(negedge clk);
      load = 1'b0;
      chk("ld_ready_drop", {31'd0, ld_ready}, 32'd0);
      for (int k = 0; k < 4; k++) exp_q.push_back(vecs[v].exp_cath[k]);
      if (vecs[v].extra) begin
        load      = 1'b1;
        load_data = 32'hFFFFFFFF;
        @(negedge clk);
        load = 1'b0;
        chk("ld_ready_still_low", {31'd0, ld_ready}, 32'd0);
      end
      wait_fd_hold();
      dp_mask    = vecs[v].dp;
      zero_blank = vecs[v].zb;
      check_frame(1'b0);
      prev_exp = vecs[v].exp_cath;
    end

    // Reset in the middle of a driven slot with a load pending
    repeat (5) @(negedge clk);
    load      = 1'b1;
    load_data = 32'h00009999;
    @(negedge clk);
    load = 1'b0;
    chk("ld_ready_drop_pre_reset", {31'd0, ld_ready}, 32'd0);
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
        @(negedge clk);
        if (An != 8'hFF) found = 1'b1;
      end
      if (!found) fail_now("timeout_drive");
    end
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_an", {24'd0, An}, 32'hFF);
    chk("async_rst_cath", {24'd0, Cath}, 32'hFF);
    chk("async_rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("async_rst_digit_idx", {29'd0, digit_idx}, 32'd0);
    dp_mask    = 8'h00;
    zero_blank = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) exp_q.push_back(8'h03);
    check_frame(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
